configcell_context_3b: RTL and testbench

- Multi-context configuration cell that drives the 3-bit `select` of a 6-input 32-bit routing mux.
- Holds one select value per context.
- Loaded serially through the CGRA configuration shift chain.
- In run mode, steps through contexts every cycle, modulo the initiation interval (II), and presents the current context's select, registered, to the downstream mux.

---
 rtl/cgra_cfg_pkg.sv | 18 +
 rtl/cgra_ctx_counter.sv | 41 ++++
 rtl/configcell_context_3b.sv | 99 +++++++++
 tb/tb_configcell_context_3b.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cgra_cfg_pkg.sv
// Shared constants, helpers and mode type for CGRA multi-context configuration cells.
package cgra_cfg_pkg;

  localparam int CFG_SEL_W    = 3;
  localparam int CFG_CONTEXTS = 4;

  // Context index width; never narrower than one bit, even for a single context.
  function automatic int ctx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    CONFIG,
    RUN,
    HOLD
  } ctx_mode_e;

endpackage

// File: rtl/cgra_ctx_counter.sv
// Modulo context counter: wraps at the clamped initiation interval, sync clear and enable.
module cgra_ctx_counter
  import cgra_cfg_pkg::*;
#(
  parameter int CONTEXTS = CFG_CONTEXTS,
  parameter int II_W     = $clog2(CONTEXTS + 1),
  parameter int CTX_W    = ctx_w(CONTEXTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [II_W-1:0]  ii,
  output logic [CTX_W-1:0] ctx
);

  // II of 0 behaves as 1; anything above the stored context count saturates.
  function automatic logic [II_W-1:0] clamp_ii(input logic [II_W-1:0] v);
    if (v == '0) return II_W'(1);
    if (v > II_W'(CONTEXTS)) return II_W'(CONTEXTS);
    return v;
  endfunction

  logic [II_W-1:0] ii_eff;
  logic [II_W-1:0] ctx_ext;
  logic            wrap;

  assign ii_eff  = clamp_ii(ii);
  assign ctx_ext = II_W'(ctx);
  // Using >= rather than == also recovers when II shrinks below the current index.
  assign wrap    = (ctx_ext + II_W'(1)) >= ii_eff;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ctx <= '0;
    end else if (en) begin
      ctx <= wrap ? '0 : ctx + CTX_W'(1);
    end
  end

endmodule

// File: rtl/configcell_context_3b.sv
// Multi-context select cell for a 6-input routing mux, loaded through the config shift chain.
// Optional even-parity check on the chain is enabled by defining CGRA_CFG_PARITY_EN.
module configcell_context_3b
  import cgra_cfg_pkg::*;
#(
  parameter int SIZE     = CFG_SEL_W,
  parameter int CONTEXTS = CFG_CONTEXTS,
  localparam int II_W    = $clog2(CONTEXTS + 1),
  localparam int CTX_W   = ctx_w(CONTEXTS)
) (
  input  logic             CGRA_Clock,
  input  logic             CGRA_Reset,
  input  logic             ConfigIn,
  output logic             ConfigOut,
  input  logic             config_en,
  input  logic             run_en,
  input  logic [II_W-1:0]  ii,
  output logic [SIZE-1:0]  select,
  output logic [CTX_W-1:0] ctx
`ifdef CGRA_CFG_PARITY_EN
  ,
  output logic             cfg_err
`endif
);

  localparam int N = SIZE * CONTEXTS;
`ifdef CGRA_CFG_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int CHAIN_N = N + PAR;

  logic [CHAIN_N-1:0] chain;
  logic [SIZE-1:0]    ctx_sel;
  logic [SIZE-1:0]    sel_nxt;
  logic               gate;
  logic               ctr_clear;
  logic               ctr_en;
  ctx_mode_e          mode;

  // The parity bit, when present, sits at bit 0 so contexts shift up by one.
  assign ctx_sel   = chain[int'(ctx) * SIZE + PAR +: SIZE];
  assign ConfigOut = chain[CHAIN_N-1];

`ifdef CGRA_CFG_PARITY_EN
  assign cfg_err = !CGRA_Reset && !config_en && (^chain);
  assign gate    = cfg_err;
`else
  assign gate    = 1'b0;
`endif

  always_comb begin
    mode      = HOLD;
    ctr_clear = 1'b0;
    ctr_en    = 1'b0;
    sel_nxt   = select;
    if (config_en) begin
      mode = CONFIG;
    end else if (run_en) begin
      mode = RUN;
    end
    case (mode)
      CONFIG: begin
        ctr_clear = 1'b1;
        sel_nxt   = '0;
      end
      RUN: begin
        ctr_en  = 1'b1;
        sel_nxt = gate ? '0 : ctx_sel;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CGRA_Clock) begin
    if (CGRA_Reset) begin
      chain  <= '0;
      select <= '0;
    end else begin
      if (config_en) chain <= {chain[CHAIN_N-2:0], ConfigIn};
      select <= sel_nxt;
    end
  end

  cgra_ctx_counter #(
    .CONTEXTS(CONTEXTS),
    .II_W    (II_W),
    .CTX_W   (CTX_W)
  ) u_ctr (
    .clk  (CGRA_Clock),
    .rst  (CGRA_Reset),
    .clear(ctr_clear),
    .en   (ctr_en),
    .ii   (ii),
    .ctx  (ctx)
  );

endmodule

// File: tb/tb_configcell_context_3b.sv
// Bench for configcell_context_3b: directed vector table, parity sequence, randomized model compare.
module tb_configcell_context_3b;

  localparam int SIZE     = 3;
  localparam int CONTEXTS = 4;
  localparam int N        = SIZE * CONTEXTS;
`ifdef CGRA_CFG_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int CHAIN_N = N + PAR;

  logic       clk = 1'b0;
  logic       rst, cin, cout, cfg, run;
  logic [2:0] ii;
  logic [2:0] sel;
  logic [1:0] ctx;
`ifdef CGRA_CFG_PARITY_EN
  logic       err;
`endif

  always #5 clk = ~clk;

  configcell_context_3b dut (
    .CGRA_Clock(clk),
    .CGRA_Reset(rst),
    .ConfigIn  (cin),
    .ConfigOut (cout),
    .config_en (cfg),
    .run_en    (run),
    .ii        (ii),
    .select    (sel),
    .ctx       (ctx)
`ifdef CGRA_CFG_PARITY_EN
    ,
    .cfg_err   (err)
`endif
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: the chain as a bit queue, front = oldest bit = ConfigOut.
  bit mq[$];
  int m_ctx, m_sel;

  function automatic int chain_bit(input int i);
    return int'(mq[CHAIN_N-1-i]);
  endfunction

  function automatic int ctx_val(input int k);
    int v = 0;
    for (int b = SIZE - 1; b >= 0; b--) v = v * 2 + chain_bit(k * SIZE + PAR + b);
    return v;
  endfunction

  function automatic int chain_par();
    int ones = 0;
    for (int i = 0; i < CHAIN_N; i++) ones += int'(mq[i]);
    return (PAR == 1) ? (ones % 2) : 0;
  endfunction

  task automatic model_step(input bit r, input bit c, input bit ru, input bit ci, input int iv);
    int iie;
    if (r) begin
      mq.delete();
      for (int i = 0; i < CHAIN_N; i++) mq.push_back(1'b0);
      m_ctx = 0;
      m_sel = 0;
    end else if (c) begin
      void'(mq.pop_front());
      mq.push_back(ci);
      m_ctx = 0;
      m_sel = 0;
    end else if (ru) begin
      iie   = (iv < 1) ? 1 : (iv > CONTEXTS) ? CONTEXTS : iv;
      m_sel = (chain_par() != 0) ? 0 : ctx_val(m_ctx);
      m_ctx = (m_ctx + 1 >= iie) ? 0 : m_ctx + 1;
    end
  endtask

  task automatic apply(input bit r, input bit c, input bit ru, input bit ci, input int iv);
    rst = r; cfg = c; run = ru; cin = ci; ii = 3'(iv);
    @(posedge clk);
    #1;
    model_step(r, c, ru, ci, iv);
  endtask

  task automatic check_model(input int cyc);
    check($sformatf("rand_sel@%0d", cyc), int'(sel), m_sel);
    check($sformatf("rand_ctx@%0d", cyc), int'(ctx), m_ctx);
    check($sformatf("rand_cout@%0d", cyc), int'(cout), int'(mq[0]));
`ifdef CGRA_CFG_PARITY_EN
    check($sformatf("rand_err@%0d", cyc), int'(err), (!rst && !cfg) ? chain_par() : 0);
`endif
  endtask

  typedef struct {
    bit    r, c, ru, ci;
    int    iv;
    int    es, ec, eo;
    string tag;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input bit c, input bit ru, input bit ci, input int iv,
                     input int es, input int ec, input int eo, input string tag);
    vec_t v;
    v.r = r; v.c = c; v.ru = ru; v.ci = ci; v.iv = iv;
    v.es = es; v.ec = ec; v.eo = eo; v.tag = tag;
    tbl.push_back(v);
  endtask

  initial begin
    int pat [12] = '{1,0,0,0,0,0,0,1,0,1,0,1};
    int out1[12] = '{0,0,0,0,0,0,1,0,1,0,1,1};
    int out0[12] = '{0,0,0,0,0,0,1,0,1,0,1,0};
    int s4  [6]  = '{5,2,0,4,5,2};
    int c4  [6]  = '{1,2,3,0,1,2};
    int s7  [5]  = '{5,2,0,4,5};
    int c7  [5]  = '{1,2,3,0,1};
    int burst;

    rst = 1'b1; cfg = 1'b1; run = 1'b1; cin = 1'b0; ii = 3'd4;
    for (int i = 0; i < CHAIN_N; i++) mq.push_back(1'b0);
    m_ctx = 0;
    m_sel = 0;

`ifndef CGRA_CFG_PARITY_EN
    add(1,1,1,0,4, 0,0,0, "reset0");
    add(1,1,1,0,4, 0,0,0, "reset1");
    for (int i = 0; i < 12; i++) add(0,1,i[0],pat[i][0],4, 0,0,(i == 11) ? 1 : 0, $sformatf("load%0d", i));
    for (int i = 0; i < 6; i++)  add(0,0,1,0,4, s4[i],c4[i],1, $sformatf("run_ii4_%0d", i));
    for (int i = 0; i < 12; i++) add(0,1,1,pat[i][0],4, 0,0,out1[i], $sformatf("reload%0d", i));
    for (int i = 0; i < 4; i++)  add(0,0,1,0,2, (i % 2 == 0) ? 5 : 2,(i % 2 == 0) ? 1 : 0,1, $sformatf("run_ii2_%0d", i));
    for (int i = 0; i < 3; i++)  add(0,0,1,0,0, 5,0,1, $sformatf("run_ii0_%0d", i));
    for (int i = 0; i < 5; i++)  add(0,0,1,0,7, s7[i],c7[i],1, $sformatf("run_ii7_%0d", i));
    add(0,0,1,0,4, 2,2,1, "pre_shrink");
    add(0,0,1,0,2, 0,0,1, "shrink_wrap");
    add(0,0,1,0,4, 5,1,1, "pre_hold");
    add(0,0,0,0,4, 5,1,1, "hold0");
    add(0,0,0,0,4, 5,1,1, "hold1");
    for (int i = 0; i < 12; i++) add(0,1,0,0,4, 0,0,out0[i], $sformatf("flush%0d", i));
    for (int i = 0; i < 4; i++)  add(0,0,1,0,4, 0,c7[i],0, $sformatf("run_zero%0d", i));
    for (int i = 0; i < 6; i++)  add(0,1,0,pat[i][0],4, 0,0,0, $sformatf("part%0d", i));
    add(1,1,0,0,4, 0,0,0, "reset_midload");
    for (int i = 0; i < 4; i++)  add(0,0,1,0,4, 0,c7[i],0, $sformatf("run_cleared%0d", i));

    foreach (tbl[i]) begin
      apply(tbl[i].r, tbl[i].c, tbl[i].ru, tbl[i].ci, tbl[i].iv);
      check({tbl[i].tag, "_sel"}, int'(sel), tbl[i].es);
      check({tbl[i].tag, "_ctx"}, int'(ctx), tbl[i].ec);
      check({tbl[i].tag, "_cout"}, int'(cout), tbl[i].eo);
    end
`else
    apply(1,1,1,0,4);
    apply(1,1,1,0,4);
    check("p_reset_sel", int'(sel), 0);
    check("p_reset_err", int'(err), 0);
    for (int i = 0; i < 12; i++) apply(0,1,0,pat[i][0],4);
    apply(0,1,0,1,4);
    check("p_err_in_config", int'(err), 0);
    for (int i = 0; i < 3; i++) begin
      apply(0,0,1,0,4);
      check($sformatf("p_bad_err%0d", i), int'(err), 1);
      check($sformatf("p_bad_sel%0d", i), int'(sel), 0);
      check($sformatf("p_bad_ctx%0d", i), int'(ctx), i + 1);
    end
    apply(0,1,0,pat[0][0],4);
    check("p_reload_err", int'(err), 0);
    for (int i = 1; i < 12; i++) apply(0,1,0,pat[i][0],4);
    apply(0,1,0,0,4);
    for (int i = 0; i < 4; i++) begin
      apply(0,0,1,0,4);
      check($sformatf("p_good_err%0d", i), int'(err), 0);
      check($sformatf("p_good_sel%0d", i), int'(sel), s4[i]);
      check($sformatf("p_good_ctx%0d", i), int'(ctx), c4[i]);
    end
`endif

    apply(1,0,0,0,4);
    check_model(-1);
    burst = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      bit r, c, ru, ci;
      r  = ($urandom_range(0, 199) == 0);
      if (burst > 0) begin
        c = 1'b1;
        burst--;
      end else if ($urandom_range(0, 99) < 6) begin
        c = 1'b1;
        burst = $urandom_range(0, 15);
      end else begin
        c = 1'b0;
      end
      ru = ($urandom_range(0, 3) != 0);
      ci = 1'($urandom_range(0, 1));
      apply(r, c, ru, ci, $urandom_range(0, 7));
      check_model(cyc);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
